// File: rtl/antilog_converter.sv
// Antilog back end of a Mitchell log-domain multiplier. It rebuilds the approximate product
// by shifting the mantissa {1,frac} serially, one bit per cycle, toward the exponent position.
module antilog_converter #(
   parameter int FRAC_W = 7,
   parameter int CHAR_W = 4,
   parameter int OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_char,
   input  logic [FRAC_W-1:0] in_frac,
   input  logic              in_fcout,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_product,
   output logic              out_ovf,
   output logic [1:0]        dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // out_valid, out_product and out_ovf stay constant until that transfer occurs.

   localparam int E_W = CHAR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [OUT_W-1:0] acc;
   logic [E_W-1:0]   cnt;
   logic             dir_left;
   logic             ovf_q;

   logic [E_W-1:0]   e;
   logic             e_left;
   logic             e_ovf;
   logic [E_W-1:0]   shift_amt;
   logic [OUT_W-1:0] mant;
   logic             accept;

   always_comb begin
      e         = {1'b0, in_char} + {{CHAR_W{1'b0}}, in_fcout};
      e_left    = (e >= E_W'(FRAC_W));
      e_ovf     = (e > E_W'(OUT_W - 1));
      shift_amt = e_left ? (e - E_W'(FRAC_W)) : (E_W'(FRAC_W) - e);
      mant      = {{(OUT_W - FRAC_W - 1){1'b0}}, 1'b1, in_frac};
      accept    = in_valid && in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Zero and overflow results need no shifting at all
               if (in_zero || e_ovf || (shift_amt == '0)) state_d = DONE;
               else                                        state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == E_W'(1)) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         dir_left <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         dir_left <= e_left;
         if (in_zero) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
         end else if (e_ovf) begin
            acc   <= '1;
            cnt   <= '0;
            ovf_q <= 1'b1;
         end else begin
            acc   <= mant;
            cnt   <= shift_amt;
            ovf_q <= 1'b0;
         end
      end else if (state_q == SHIFT) begin
         // Left shifts never exceed e-FRAC_W <= OUT_W-1-FRAC_W, so no MSB is lost
         acc <= dir_left ? (acc << 1) : (acc >> 1);
         cnt <= cnt - E_W'(1);
      end
   end

   assign out_product = acc;
   assign out_ovf     = ovf_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_antilog_converter.sv
// Randomized scoreboard bench for antilog_converter: a driver queues expected products from an
// arithmetic reference model, and a monitor pops and compares whenever a product is presented.
module tb_antilog_converter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_char = '0;
   logic [6:0]  in_frac = '0;
   logic        in_fcout = 1'b0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_product;
   logic        out_ovf;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cycle = 0;
   int ready_mode = 0;   // 0 random, 1 held low, 2 held high

   logic [15:0] exp_q[$];
   logic        exp_ovf_q[$];
   int          exp_lat_q[$];
   int          acc_cyc_q[$];

   antilog_converter dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_char     (in_char),
      .in_frac     (in_frac),
      .in_fcout    (in_fcout),
      .in_zero     (in_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_ovf     (out_ovf),
      .dbg_state   (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   // sink: out_ready changes just after the rising edge so it is stable at every sample point
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         1:       out_ready = 1'b0;
         2:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // Reference: product = floor((1+s) * 2^e) with s = frac/128, done in plain integers
   function automatic void model(input logic [3:0] ch, input logic [6:0] fr, input logic fc,
                                 input logic z, output logic [15:0] p, output logic o,
                                 output int lat);
      int e;
      int m;
      e = int'(ch) + int'(fc);
      m = 128 + int'(fr);
      if (z) begin
         p = 16'd0; o = 1'b0; lat = 1;
      end else if (e > 15) begin
         p = 16'hFFFF; o = 1'b1; lat = 1;
      end else begin
         p   = 16'((m * (1 << e)) / 128);
         o   = 1'b0;
         lat = 1 + ((e >= 7) ? (e - 7) : (7 - e));
      end
   endfunction

   // driver tasks
   task automatic send(input logic [3:0] ch, input logic [6:0] fr, input logic fc, input logic z);
      int          waited;
      logic [15:0] p;
      logic        o;
      int          lat;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = ch;
      in_frac  = fr;
      in_fcout = fc;
      in_zero  = z;
      while (!in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      model(ch, fr, fc, z, p, o, lat);
      exp_q.push_back(p);
      exp_ovf_q.push_back(o);
      exp_lat_q.push_back(lat);
      acc_cyc_q.push_back(cycle + 1);
      @(posedge clk);
   endtask

   task automatic idle_input();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      exp_ovf_q.delete();
      exp_lat_q.delete();
      acc_cyc_q.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int waited;
      waited = 0;
      while (!out_valid && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!out_valid) check(name, 0, 1);
   endtask

   task automatic drain(input string name);
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // scoreboard monitor
   logic        prev_v = 1'b0;
   logic        prev_r = 1'b0;
   logic [15:0] held_p = '0;
   logic        held_o = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
         prev_r = 1'b0;
      end else begin
         if (out_valid) begin
            if (prev_v && !prev_r) begin
               check("hold_product", int'(out_product), int'(held_p));
               check("hold_ovf", int'(out_ovf), int'(held_o));
               check("hold_in_ready", int'(in_ready), 0);
            end else if (exp_q.size() == 0) begin
               check("unexpected_output", int'(out_product), -1);
            end else begin
               check("product", int'(out_product), int'(exp_q.pop_front()));
               check("ovf", int'(out_ovf), int'(exp_ovf_q.pop_front()));
               check("latency", cycle - acc_cyc_q.pop_front() + 1, exp_lat_q.pop_front());
            end
            held_p = out_product;
            held_o = out_ovf;
         end
         prev_v = out_valid;
         prev_r = out_ready;
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_product", int'(out_product), 0);
      check("reset_ovf", int'(out_ovf), 0);

      // directed corners, sink always ready
      ready_mode = 2;
      send(4'd5, 7'h00, 1'b0, 1'b0);
      send(4'd14, 7'h7E, 1'b1, 1'b0);
      send(4'd0, 7'h00, 1'b0, 1'b0);
      send(4'd15, 7'h55, 1'b1, 1'b0);
      send(4'd14, 7'h33, 1'b0, 1'b1);
      send(4'd6, 7'h2A, 1'b1, 1'b0);
      send(4'd15, 7'h7F, 1'b0, 1'b0);
      send(4'd15, 7'h7F, 1'b1, 1'b1);
      idle_input();
      drain("drain_directed");

      // sink stalls for 5 cycles with a product presented
      ready_mode = 1;
      send(4'd5, 7'h00, 1'b0, 1'b0);
      idle_input();
      wait_valid("hold_valid_timeout");
      repeat (5) @(negedge clk);
      ready_mode = 2;
      drain("drain_hold");

      // reset in the middle of a long right shift discards the result
      send(4'd0, 7'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      pulse_reset();
      @(negedge clk);
      check("midshift_rst_in_ready", int'(in_ready), 1);
      check("midshift_rst_out_valid", int'(out_valid), 0);
      check("midshift_rst_product", int'(out_product), 0);
      repeat (15) @(negedge clk);
      check("midshift_no_output", int'(out_valid), 0);

      // randomized traffic with random backpressure, back-to-back offers
      ready_mode = 0;
      for (int i = 0; i < 150; i++) begin
         send(4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 3) == 0) idle_input();
      end
      idle_input();
      ready_mode = 2;
      drain("drain_random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
